// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline control: opcode field constants,
// forwarding-select encodings and the per-stage shadow record.
package core_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_M    = 2'd1;
  localparam logic [1:0] FWD_W    = 2'd2;

  typedef struct packed {
    logic       valid;
    logic       wen;
    logic       is_load;
    logic [4:0] rd;
  } shadow_t;

  // x0 is hardwired to zero, so it never produces a dependency.
  function automatic logic rd_match(input shadow_t s, input logic [4:0] r);
    return s.valid && s.wen && (s.rd != 5'd0) && (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational opcode classifier: which source registers an instruction
// reads, whether it writes rd, and whether it is a load.
module hazard_decode
  import core_pkg::*;
(
  input  logic       valid_i,
  input  logic [4:0] opcode_i,
  output logic       rs1_used_o,
  output logic       rs2_used_o,
  output logic       wen_o,
  output logic       is_load_o
);

  always_comb begin
    rs1_used_o = valid_i && !((opcode_i == OP_LUI) || (opcode_i == OP_AUIPC) ||
                              (opcode_i == OP_JAL));
    rs2_used_o = valid_i && ((opcode_i == OP_BRANCH) || (opcode_i == OP_STORE) ||
                             (opcode_i == OP_OP));
    wen_o      = valid_i && !((opcode_i == OP_BRANCH) || (opcode_i == OP_STORE));
    is_load_o  = valid_i && (opcode_i == OP_LOAD);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, jump/branch flush and E-stage forwarding control for the
// 5-stage RV32I core, with saturating stall/flush event counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_jb,
  output logic             stall,
  output logic             jb,
  output logic [1:0]       rs1_fwd_sel,
  output logic [1:0]       rs2_fwd_sel,
  output logic             id_rs1_wb_byp,
  output logic             id_rs2_wb_byp,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic rs1_used, rs2_used, dec_wen, dec_load;

  hazard_decode u_dec (
    .valid_i    (id_valid),
    .opcode_i   (id_opcode),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used),
    .wen_o      (dec_wen),
    .is_load_o  (dec_load)
  );

  shadow_t          e_q, m_q, w_q, e_d;
  logic [1:0]       rs1_sel_q, rs1_sel_d, rs2_sel_q, rs2_sel_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             stall_c, bubble;
  logic             e_hit1, e_hit2, m_hit1, m_hit2;

  always_comb begin
    e_hit1 = rs1_used && rd_match(e_q, id_rs1);
    e_hit2 = rs2_used && rd_match(e_q, id_rs2);
    m_hit1 = rs1_used && rd_match(m_q, id_rs1);
    m_hit2 = rs2_used && rd_match(m_q, id_rs2);

    // A squashed D instruction cannot stall; the flush wins.
    stall_c = !ex_jb && e_q.is_load && (e_hit1 || e_hit2);
    bubble  = stall_c || ex_jb;

    e_d = '{valid: id_valid, wen: dec_wen, is_load: dec_load, rd: id_rd};
    if (bubble) e_d = '{valid: 1'b0, wen: 1'b0, is_load: 1'b0, rd: id_rd};

    rs1_sel_d = FWD_NONE;
    rs2_sel_d = FWD_NONE;
    if (!bubble) begin
      if (e_hit1 && !e_q.is_load) rs1_sel_d = FWD_M;
      else if (m_hit1)            rs1_sel_d = FWD_W;
      if (e_hit2 && !e_q.is_load) rs2_sel_d = FWD_M;
      else if (m_hit2)            rs2_sel_d = FWD_W;
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ex_jb && (flush_cnt_q != {CNT_W{1'b1}}))   flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      rs1_sel_q   <= FWD_NONE;
      rs2_sel_q   <= FWD_NONE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= e_q;
      w_q         <= m_q;
      rs1_sel_q   <= rs1_sel_d;
      rs2_sel_q   <= rs2_sel_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall         = stall_c;
  assign jb            = ex_jb;
  assign rs1_fwd_sel   = rs1_sel_q;
  assign rs2_fwd_sel   = rs2_sel_q;
  assign id_rs1_wb_byp = rs1_used && rd_match(w_q, id_rs1);
  assign id_rs2_wb_byp = rs2_used && rd_match(w_q, id_rs2);
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios followed by random
// instruction streams, compared against an instruction-history model.
module tb_hazard_ctrl;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_opcode, id_rs1, id_rs2, id_rd;
  logic        ex_jb;
  logic        stall, jb, id_rs1_wb_byp, id_rs2_wb_byp;
  logic [1:0]  rs1_fwd_sel, rs2_fwd_sel;
  logic [31:0] stall_cnt, flush_cnt;
  logic        s_stall, s_jb, s_b1, s_b2;
  logic [1:0]  s_sel1, s_sel2;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_jb(ex_jb),
    .stall(stall), .jb(jb), .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
    .id_rs1_wb_byp(id_rs1_wb_byp), .id_rs2_wb_byp(id_rs2_wb_byp),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_jb(ex_jb),
    .stall(s_stall), .jb(s_jb), .rs1_fwd_sel(s_sel1), .rs2_fwd_sel(s_sel2),
    .id_rs1_wb_byp(s_b1), .id_rs2_wb_byp(s_b2),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Model: what entered E on each of the last three cycles (index 2 = newest).
  typedef struct {
    bit       v;
    bit       wr;
    bit       ld;
    bit [4:0] rd;
  } ent_t;

  ent_t       hist[$];
  longint     m_stalls, m_flushes;
  logic [1:0] m_sel1, m_sel2;
  int         checks = 0;
  int         errors = 0;

  bit         d_v, d_jb;
  logic [4:0] d_op, d_r1, d_r2, d_rd;
  bit         last_stall, last_byp1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void classify(input bit v, input logic [4:0] op,
                                   output bit u1, output bit u2, output bit wr, output bit ld);
    u1 = 1'b0; u2 = 1'b0; wr = 1'b0; ld = 1'b0;
    if (v) begin
      case (op)
        OP_LUI, OP_AUIPC:     begin u1 = 0; u2 = 0; wr = 1; end
        OP_JAL:               begin u1 = 0; u2 = 0; wr = 1; end
        OP_BRANCH, OP_STORE:  begin u1 = 1; u2 = 1; wr = 0; end
        OP_OP:                begin u1 = 1; u2 = 1; wr = 1; end
        OP_LOAD:              begin u1 = 1; u2 = 0; wr = 1; ld = 1; end
        default:              begin u1 = 1; u2 = 0; wr = 1; end
      endcase
    end
  endfunction

  function automatic bit writes(input ent_t e, input logic [4:0] r);
    return e.v && e.wr && (e.rd != 0) && (e.rd == r);
  endfunction

  function automatic logic [31:0] sat7(input longint n);
    return (n > 7) ? 32'd7 : 32'(n);
  endfunction

  task automatic model_reset();
    ent_t b;
    b = '{v: 0, wr: 0, ld: 0, rd: 0};
    hist.delete();
    repeat (3) hist.push_back(b);
    m_stalls = 0; m_flushes = 0;
    m_sel1 = FWD_NONE; m_sel2 = FWD_NONE;
  endtask

  task automatic set_d(input bit v, input logic [4:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input bit j);
    d_v = v; d_op = op; d_r1 = r1; d_r2 = r2; d_rd = rd; d_jb = j;
  endtask

  // One clock: drive D, check everything against the model, clock, advance model.
  task automatic step();
    bit   u1, u2, wr, ld, exp_stall, b1, b2;
    ent_t e, m, w, nxt;
    id_valid = d_v; id_opcode = d_op; id_rs1 = d_r1; id_rs2 = d_r2; id_rd = d_rd; ex_jb = d_jb;
    #1;
    classify(d_v, d_op, u1, u2, wr, ld);
    w = hist[0]; m = hist[1]; e = hist[2];
    exp_stall = !d_jb && e.ld && ((u1 && writes(e, d_r1)) || (u2 && writes(e, d_r2)));
    b1 = u1 && writes(w, d_r1);
    b2 = u2 && writes(w, d_r2);
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("jb", 32'(jb), 32'(d_jb));
    chk("wb_byp1", 32'(id_rs1_wb_byp), 32'(b1));
    chk("wb_byp2", 32'(id_rs2_wb_byp), 32'(b2));
    chk("fwd1", 32'(rs1_fwd_sel), 32'(m_sel1));
    chk("fwd2", 32'(rs2_fwd_sel), 32'(m_sel2));
    chk("stall_cnt", stall_cnt, 32'(m_stalls));
    chk("flush_cnt", flush_cnt, 32'(m_flushes));
    chk("sat_stall_cnt", 32'(s_stall_cnt), sat7(m_stalls));
    chk("sat_flush_cnt", 32'(s_flush_cnt), sat7(m_flushes));
    last_stall = stall;
    last_byp1  = id_rs1_wb_byp;
    @(posedge clk);
    if (exp_stall || d_jb) begin
      nxt = '{v: 0, wr: 0, ld: 0, rd: 0};
      m_sel1 = FWD_NONE; m_sel2 = FWD_NONE;
    end else begin
      nxt = '{v: d_v, wr: wr, ld: ld, rd: d_rd};
      m_sel1 = (u1 && writes(e, d_r1) && !e.ld) ? FWD_M : (u1 && writes(m, d_r1)) ? FWD_W : FWD_NONE;
      m_sel2 = (u2 && writes(e, d_r2) && !e.ld) ? FWD_M : (u2 && writes(m, d_r2)) ? FWD_W : FWD_NONE;
    end
    hist.push_back(nxt);
    void'(hist.pop_front());
    if (exp_stall) m_stalls++;
    if (d_jb) m_flushes++;
    #1;
  endtask

  logic [4:0] ops[10];

  initial begin
    ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_OP, OP_OPIMM, OP_LOAD};
    rst = 1'b0;
    set_d(0, 0, 0, 0, 0, 0);
    id_valid = 0; id_opcode = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_jb = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_jb", 32'(jb), 32'd0);
    chk("rst_fwd1", 32'(rs1_fwd_sel), 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Load-use: one bubble, then forward from W.
    set_d(1, OP_LOAD, 1, 0, 5, 0); step();
    set_d(1, OP_OP, 5, 1, 6, 0);   step();
    chk("lu_stall_on", 32'(last_stall), 32'd1);
    step();
    chk("lu_stall_off", 32'(last_stall), 32'd0);
    chk("lu_fwd_w", 32'(rs1_fwd_sel), 32'(FWD_W));
    chk("lu_cnt", stall_cnt, 32'd1);

    // EX->EX forwarding on both operands.
    set_d(1, OP_OPIMM, 0, 0, 3, 0); step();
    set_d(1, OP_OP, 3, 3, 4, 0);    step();
    chk("ex_nostall", 32'(last_stall), 32'd0);
    chk("ex_fwd1", 32'(rs1_fwd_sel), 32'(FWD_M));
    chk("ex_fwd2", 32'(rs2_fwd_sel), 32'(FWD_M));

    // Youngest producer wins; with a gap the value comes from W.
    set_d(1, OP_OPIMM, 0, 0, 2, 0); step();
    set_d(1, OP_OPIMM, 2, 0, 2, 0); step();
    set_d(1, OP_OP, 2, 0, 7, 0);    step();
    chk("prio_m", 32'(rs1_fwd_sel), 32'(FWD_M));
    set_d(1, OP_OPIMM, 0, 0, 2, 0); step();
    set_d(1, OP_OPIMM, 0, 0, 0, 0); step();
    set_d(1, OP_OP, 2, 0, 7, 0);    step();
    chk("prio_w", 32'(rs1_fwd_sel), 32'(FWD_W));

    // Flush beats stall.
    set_d(1, OP_LOAD, 1, 0, 5, 0); step();
    set_d(1, OP_OP, 5, 1, 6, 1);   step();
    chk("fl_stall", 32'(last_stall), 32'd0);
    chk("fl_sel", 32'(rs1_fwd_sel), 32'd0);
    chk("fl_flush_cnt", flush_cnt, 32'd1);
    chk("fl_stall_cnt", stall_cnt, 32'd1);

    // x0 never hazards; W write-through bypass.
    set_d(1, OP_LOAD, 1, 0, 0, 0); step();
    set_d(1, OP_OP, 0, 0, 1, 0);   step();
    chk("x0_stall", 32'(last_stall), 32'd0);
    chk("x0_sel", 32'(rs1_fwd_sel), 32'd0);
    set_d(1, OP_OPIMM, 0, 0, 9, 0); step();
    set_d(1, OP_OPIMM, 0, 0, 0, 0); step(); step();
    set_d(1, OP_OP, 9, 0, 10, 0);   step();
    chk("wb_byp9", 32'(last_byp1), 32'd1);

    // Asynchronous reset with a load in E.
    set_d(1, OP_LOAD, 1, 0, 5, 0); step();
    set_d(1, OP_OP, 5, 1, 6, 0);
    id_valid = d_v; id_opcode = d_op; id_rs1 = d_r1; id_rs2 = d_r2; id_rd = d_rd; ex_jb = 0;
    #1;
    chk("pre_rst_stall", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_scnt", stall_cnt, 32'd0);
    chk("mid_rst_fcnt", flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step();
    chk("post_rst_stall", 32'(last_stall), 32'd0);
    chk("post_rst_fwd", 32'(rs1_fwd_sel), 32'd0);

    // Random streams; a stalled D instruction is held until it advances.
    for (int i = 0; i < 600; i++) begin
      if (!last_stall || d_jb)
        set_d($urandom_range(0, 9) != 0,
              ($urandom_range(0, 15) == 0) ? 5'($urandom) : ops[$urandom_range(0, 9)],
              5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
              5'($urandom_range(0, 6)), 1'b0);
      d_jb = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32I core; the producer of the flush (enable_jb) and stall (enable_stall) controls that the D/E pipeline registers consume. It shadows rd/write-enable/load status of instructions in E, M and W, detects load-use hazards, and squashes wrong-path instructions on a resolved jump/branch. It also issues registered E-stage forwarding selects and keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 32, width of the stall and flush performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  D stage holds a real instruction
id_opcode  in  5  instr[6:2] of the D-stage instruction
id_rs1  in  5  D-stage rs1 index
id_rs2  in  5  D-stage rs2 index
id_rd  in  5  D-stage rd index
ex_jb  in  1  E stage resolved a taken branch, JAL or JALR this cycle
stall  out  1  hold PC and Reg_D; insert bubble into Reg_E (drives enable_stall)
jb  out  1  flush Reg_D and Reg_E (drives enable_jb); equals ex_jb
rs1_fwd_sel  out  2  E-stage rs1 source: 0 regfile, 1 from M, 2 from W
rs2_fwd_sel  out  2  E-stage rs2 source, same encoding
id_rs1_wb_byp  out  1  D-stage rs1 takes the W write data (regfile write-through)
id_rs2_wb_byp  out  1  D-stage rs2 takes the W write data
stall_cnt  out  CNT_W  cycles with stall=1, saturating
flush_cnt  out  CNT_W  cycles with jb=1, saturating

Behaviour:
- Decode of the D instruction (combinational):
  - rs1_used: all opcodes except LUI(01101), AUIPC(00101), JAL(11011).
  - rs2_used: BRANCH(11000), STORE(01000), OP(01100).
  - wen: all except BRANCH and STORE.
  - is_load: LOAD(00000).
  - All of these are gated by id_valid.
- Shadow state per stage E/M/W: valid, wen, is_load, rd[4:0].
- Every posedge:
  - W <= M; M <= E.
  - E <= D decode if !stall && !jb; otherwise E <= bubble (valid=0, wen=0).
- Hazard test, match(x,r): x.valid && x.wen && x.rd != 0 && x.rd == r.
- stall (combinational) = !ex_jb && E.is_load && ((rs1_used && match(E,id_rs1)) || (rs2_used && match(E,id_rs2))).
  - Exactly one bubble per load-use; on the next cycle the load is in M, so stall drops.
- jb = ex_jb, combinational. jb has priority over stall: when both would assert, stall=0, because the D instruction is squashed.
- Forward selects are registered and updated on the same edge D advances to E:
  - rs1_fwd_sel <= 1 if rs1_used && match(E,id_rs1) && !E.is_load; else 2 if rs1_used && match(M,id_rs1); else 0.
  - rs2_fwd_sel uses the same rule with rs2.
  - M outranks W.
  - On bubble insertion (stall or jb), both selects <= 0.
- id_rs1_wb_byp = rs1_used && match(W,id_rs1); id_rs2_wb_byp likewise. Both combinational.
- Counters:
  - +1 per cycle with stall=1 (stall_cnt) or jb=1 (flush_cnt).
  - Hold at 2^CNT_W-1.
  - Cleared only by reset.
- Reset (rst=0, asynchronous):
  - All shadow valid/wen/is_load = 0, all rd = 0.
  - Selects = 0, counters = 0.
  - stall=0 and jb=0, provided ex_jb=0.
  - Assertion mid-operation discards in-flight state immediately; the first cycle after release behaves as an empty pipeline.
- x0 never causes a hazard, stall or forward.

Decomposition:
- Shared package (core_pkg): 5-bit opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_OP, OP_OPIMM) and FWD_NONE/FWD_M/FWD_W = 2'd0/1/2.
- One natural sub-module, hazard_decode: combinational opcode -> {rs1_used, rs2_used, wen, is_load}. Also reusable by the E-stage ALU control.

Test Plan:
- Load-use: LW x5 in D, then ADD x6,x5,x1 in D while LW is in E. Required: stall=1 for exactly 1 cycle, ADD enters E a cycle later with rs1_fwd_sel=2, stall_cnt=1.
- EX->EX forward: ADDI x3,x0,7 followed by SUB x4,x3,x3. Required: SUB in E with rs1_fwd_sel=1 and rs2_fwd_sel=1, stall=0.
- Priority M over W: ADDI x2; ADDI x2; ADD x7,x2,x0. Required: rs1_fwd_sel=1, not 2. Repeat with one NOP gap. Required: rs1_fwd_sel=2.
- Flush vs stall: ex_jb=1 in the same cycle a load-use would stall. Required: jb=1, stall=0, E becomes a bubble, next-cycle selects=0, flush_cnt=1, stall_cnt unchanged.
- x0 and W bypass: LW x0 then ADD x1,x0,x0. Required: no stall, selects 0. Instruction reading x9 while W writes x9. Required: id_rs1_wb_byp=1.
- Reset mid-run: drop rst low while a load sits in E. Required: stall=0 and counters=0 immediately. After release, an ADD using the load's rd gets no stall and no forward.
